// File: rtl/ysyx_22050039_lsu_pkg.sv
// Shared types and constants for the ysyx_22050039 load/store unit.
// Op word layout: [3]=store, [2]=unsigned, [1:0]=size.
package ysyx_22050039_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;
  localparam int OP_SIZE_MSB = 1;
  localparam int OP_SIZE_LSB = 0;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

endpackage

// File: rtl/ysyx_22050039_lsu_align.sv
// Byte-lane steering for the LSU: store mask/data placement, load extraction
// with sign/zero extension, and natural-alignment check.
module ysyx_22050039_lsu_align
  import ysyx_22050039_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [63:0]     rdata,
  output logic [7:0]      wmask,
  output logic [63:0]     wdata_lane,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [63:0] raw;
  logic [7:0]  base_mask;

  assign raw        = rdata >> {off, 3'b000};
  assign wdata_lane = 64'(wdata) << {off, 3'b000};
  assign wmask      = base_mask << off;

  // The unsigned bit only matters for sub-doubleword sizes.
  always_comb begin
    base_mask  = MASK_B;
    load_data  = '0;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        base_mask = MASK_B;
        load_data = {{(XLEN-8){~uns & raw[7]}}, raw[7:0]};
      end
      SZ_H: begin
        base_mask  = MASK_H;
        load_data  = {{(XLEN-16){~uns & raw[15]}}, raw[15:0]};
        misaligned = off[0];
      end
      SZ_W: begin
        base_mask  = MASK_W;
        load_data  = {{(XLEN-32){~uns & raw[31]}}, raw[31:0]};
        misaligned = |off[1:0];
      end
      default: begin
        base_mask  = MASK_D;
        load_data  = raw[XLEN-1:0];
        misaligned = |off;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22050039_lsu.sv
// Multi-cycle load/store unit: one aligned 64-bit valid/ready memory
// transaction per request, result held for writeback until consumed.
module ysyx_22050039_lsu
  import ysyx_22050039_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [RD_W-1:0] req_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [63:0]     mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [63:0]     mem_resp_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_wen,
  output logic            wb_err
);

  state_t          state_reg, state_next;
  logic [3:0]      op_reg;
  logic [XLEN-1:0] addr_reg, wdata_reg, data_reg;
  logic [RD_W-1:0] rd_reg;
  logic            err_reg;

  logic [1:0]      cur_size;
  logic            cur_uns;
  logic [2:0]      cur_off;
  logic [7:0]      lane_mask;
  logic [63:0]     lane_wdata;
  logic [XLEN-1:0] load_data;
  logic            misaligned;

  // In IDLE the aligner looks at the incoming request so the alignment check
  // is ready on the accept edge; afterwards it works from the captured copy.
  assign cur_size = (state_reg == IDLE) ? req_op[OP_SIZE_MSB:OP_SIZE_LSB]
                                        : op_reg[OP_SIZE_MSB:OP_SIZE_LSB];
  assign cur_uns  = (state_reg == IDLE) ? req_op[OP_UNSIGNED] : op_reg[OP_UNSIGNED];
  assign cur_off  = (state_reg == IDLE) ? req_addr[2:0] : addr_reg[2:0];

  ysyx_22050039_lsu_align #(.XLEN(XLEN)) u_align (
    .size       (cur_size),
    .uns        (cur_uns),
    .off        (cur_off),
    .wdata      (wdata_reg),
    .rdata      (mem_resp_rdata),
    .wmask      (lane_mask),
    .wdata_lane (lane_wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_wen   = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    wb_valid      = 1'b0;
    wb_data       = '0;
    wb_rd         = '0;
    wb_wen        = 1'b0;
    wb_err        = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = rst;
        if (req_valid) state_next = misaligned ? DONE : REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_wen   = op_reg[OP_STORE];
        mem_req_addr  = {addr_reg[XLEN-1:3], 3'b000};
        mem_req_wdata = lane_wdata;
        mem_req_wmask = lane_mask;
        if (mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) state_next = DONE;
      end
      default: begin
        wb_valid = 1'b1;
        wb_data  = data_reg;
        wb_rd    = rd_reg;
        wb_wen   = ~op_reg[OP_STORE] & ~err_reg;
        wb_err   = err_reg;
        if (wb_ready) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg    <= req_op;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            rd_reg    <= req_rd;
            data_reg  <= '0;
            err_reg   <= misaligned;
          end
        end
        WAIT: begin
          if (mem_resp_valid) data_reg <= op_reg[OP_STORE] ? '0 : load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Directed self-checking bench for ysyx_22050039_lsu.
module tb_ysyx_22050039_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic        wb_err;

  int checks = 0;
  int failures = 0;

  ysyx_22050039_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(); tick();
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", mem_req_valid); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    rst = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (wb_data !== 64'h0 || mem_req_wmask !== 8'h0 || mem_req_addr !== 64'h0)
      begin failures++; $display("FAIL reset_outputs wb_data=%h wmask=%h addr=%h exp=0", wb_data, mem_req_wmask, mem_req_addr); end
    $display("txn reset done");
  endtask

  task automatic test_load_byte(input logic [63:0] rdata, input logic uns, input logic [63:0] exp);
    req_valid = 1'b1; req_op = {1'b0, uns, 2'b00}; req_addr = 64'h8000_0003; req_rd = 5'd7; req_wdata = 64'h0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL lb_ready got=%b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b0)
      begin failures++; $display("FAIL lb_memreq valid=%b wen=%b exp=1/0", mem_req_valid, mem_req_wen); end
    checks++; if (mem_req_addr !== 64'h8000_0000) begin failures++; $display("FAIL lb_addr got=%h exp=80000000", mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_wen !== 1'b1 || wb_err !== 1'b0 || wb_rd !== 5'd7)
      begin failures++; $display("FAIL lb_wb valid=%b wen=%b err=%b rd=%0d exp=1/1/0/7", wb_valid, wb_wen, wb_err, wb_rd); end
    checks++; if (wb_data !== exp) begin failures++; $display("FAIL lb_data got=%h exp=%h", wb_data, exp); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1)
      begin failures++; $display("FAIL lb_release wb_valid=%b req_ready=%b exp=0/1", wb_valid, req_ready); end
    $display("txn LB%s rdata=%h wb_data=%h", uns ? "U" : "", rdata, wb_data);
  endtask

  task automatic test_store_half;
    req_valid = 1'b1; req_op = 4'b1001; req_addr = 64'h8000_0006; req_wdata = 64'hABCD; req_rd = 5'd3;
    tick();
    req_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b1)
      begin failures++; $display("FAIL sh_memreq valid=%b wen=%b exp=1/1", mem_req_valid, mem_req_wen); end
    checks++; if (mem_req_wmask !== 8'hC0) begin failures++; $display("FAIL sh_wmask got=%h exp=c0", mem_req_wmask); end
    checks++; if (mem_req_wdata !== 64'hABCD_0000_0000_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=abcd000000000000", mem_req_wdata); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_resp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_wen !== 1'b0 || wb_err !== 1'b0 || wb_data !== 64'h0)
      begin failures++; $display("FAIL sh_wb valid=%b wen=%b err=%b data=%h exp=1/0/0/0", wb_valid, wb_wen, wb_err, wb_data); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    $display("txn SH addr=80000006 wmask=c0 done");
  endtask

  task automatic test_misaligned;
    req_valid = 1'b1; req_op = 4'b0010; req_addr = 64'h8000_0002; req_rd = 5'd9;
    tick();
    req_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_memreq got=%b exp=0", mem_req_valid); end
    checks++; if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_wen !== 1'b0 || wb_data !== 64'h0)
      begin failures++; $display("FAIL mis_wb valid=%b err=%b wen=%b data=%h exp=1/1/0/0", wb_valid, wb_err, wb_wen, wb_data); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b1)
      begin failures++; $display("FAIL mis_after memvalid=%b ready=%b exp=0/1", mem_req_valid, req_ready); end
    $display("txn LW misaligned addr=80000002 err=1");
  endtask

  task automatic test_backpressure;
    int bad_req, bad_wb;
    bad_req = 0; bad_wb = 0;
    req_valid = 1'b1; req_op = 4'b0011; req_addr = 64'h8000_0008; req_rd = 5'd12;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0008 || mem_req_wmask !== 8'hFF || req_ready !== 1'b0) bad_req++;
      tick();
    end
    checks++; if (bad_req != 0) begin failures++; $display("FAIL bp_mem_hold unstable_cycles=%0d exp=0", bad_req); end
    checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL bp_mem_still got=%b exp=1", mem_req_valid); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      // stray response pulses while in DONE must not disturb the result
      mem_resp_valid = 1'b1; mem_resp_rdata = 64'h5555_5555_5555_5555;
      if (wb_valid !== 1'b1 || wb_data !== 64'h0123_4567_89AB_CDEF || wb_rd !== 5'd12 || req_ready !== 1'b0) bad_wb++;
      tick();
    end
    mem_resp_valid = 1'b0;
    checks++; if (bad_wb != 0) begin failures++; $display("FAIL bp_wb_hold unstable_cycles=%0d exp=0", bad_wb); end
    checks++; if (wb_data !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL bp_wb_data got=%h exp=0123456789abcdef", wb_data); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1)
      begin failures++; $display("FAIL bp_release wb_valid=%b req_ready=%b exp=0/1", wb_valid, req_ready); end
    $display("txn LD backpressure data=%h", 64'h0123_4567_89AB_CDEF);
  endtask

  task automatic test_back_to_back;
    int ready_seen;
    ready_seen = 0;
    mem_req_ready = 1'b1; wb_ready = 1'b1;
    req_valid = 1'b1; req_op = 4'b0011; req_addr = 64'h8000_0008; req_rd = 5'd4;
    tick();
    // second request presented immediately and held until taken
    req_op = 4'b1011; req_addr = 64'h8000_0010; req_wdata = 64'hFEED_FACE_0BAD_F00D; req_rd = 5'd0;
    if (req_ready === 1'b1) ready_seen++;
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    if (req_ready === 1'b1) ready_seen++;
    tick();
    mem_resp_valid = 1'b0;
    if (req_ready === 1'b1) ready_seen++;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hDEAD_BEEF_CAFE_F00D || wb_wen !== 1'b1)
      begin failures++; $display("FAIL b2b_ld valid=%b data=%h wen=%b exp=1/deadbeefcafef00d/1", wb_valid, wb_data, wb_wen); end
    tick();
    checks++; if (ready_seen != 0 || req_ready !== 1'b1 || wb_valid !== 1'b0)
      begin failures++; $display("FAIL b2b_ready_timing early=%0d ready_at4=%b wb_valid=%b exp=0/1/0", ready_seen, req_ready, wb_valid); end
    tick();
    req_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b1 || mem_req_addr !== 64'h8000_0010 ||
                  mem_req_wmask !== 8'hFF || mem_req_wdata !== 64'hFEED_FACE_0BAD_F00D)
      begin failures++; $display("FAIL b2b_sd valid=%b wen=%b addr=%h mask=%h wdata=%h", mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wmask, mem_req_wdata); end
    tick();
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_wen !== 1'b0 || wb_data !== 64'h0)
      begin failures++; $display("FAIL b2b_sd_ack valid=%b wen=%b data=%h exp=1/0/0", wb_valid, wb_wen, wb_data); end
    tick();
    mem_req_ready = 1'b0; wb_ready = 1'b0;
    $display("txn back-to-back LD 80000008 then SD 80000010");
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_op = 4'b0010; req_addr = 64'h8000_0004; req_rd = 5'd5;
    tick();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0)
      begin failures++; $display("FAIL rstmid_during memvalid=%b wb_valid=%b exp=0/0", mem_req_valid, wb_valid); end
    rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h7777_7777_7777_7777;
    tick();
    mem_resp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1)
      begin failures++; $display("FAIL rstmid_late_resp wb_valid=%b req_ready=%b exp=0/1", wb_valid, req_ready); end
    tick();
    checks++; if (wb_valid !== 1'b0 || mem_req_valid !== 1'b0)
      begin failures++; $display("FAIL rstmid_idle wb_valid=%b memvalid=%b exp=0/0", wb_valid, mem_req_valid); end
    $display("txn reset during WAIT, late response dropped");
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_addr = 64'h0; req_wdata = 64'h0; req_rd = 5'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0; wb_ready = 1'b0;
    test_reset();
    test_load_byte(64'h1122_3344_5566_7788, 1'b0, 64'h0000_0000_0000_0055);
    test_load_byte(64'h1122_3344_8566_7788, 1'b0, 64'hFFFF_FFFF_FFFF_FF85);
    test_load_byte(64'h1122_3344_8566_7788, 1'b1, 64'h0000_0000_0000_0085);
    test_store_half();
    test_misaligned();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050039_lsu.md
Name: ysyx_22050039_lsu

Overview:
Load/store unit directly downstream of the execute stage in the ysyx_22050039 RV64 core. It takes the effective address computed by execute, plus store data and the op code. It performs one aligned 64-bit memory transaction over a valid/ready bus, then returns sign-/zero-extended load data, or a store acknowledge, to writeback. It replaces the combinational DPI memory read in execute with a multi-cycle, stallable path.

Parameters:
XLEN, 64, datapath and address width
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req_valid  in  1  execute presents a memory op
req_ready  out  1  LSU can accept a request
req_op  in  4  [3]=store, [2]=unsigned (loads only), [1:0]=size (0 B, 1 H, 2 W, 3 D)
req_addr  in  XLEN  effective address (src1+imm from execute)
req_wdata  in  XLEN  store data, value in low bytes
req_rd  in  RD_W  load destination register
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  1=write, 0=read
mem_req_addr  out  XLEN  req_addr with bits [2:0] cleared
mem_req_wdata  out  64  store data shifted to lane
mem_req_wmask  out  8  byte-enable mask
mem_resp_valid  in  1  read data / write ack valid (single cycle)
mem_resp_rdata  in  64  aligned 64-bit read data
wb_valid  out  1  result available to writeback
wb_ready  in  1  writeback consumes result
wb_data  out  XLEN  extended load data; 0 for stores
wb_rd  out  RD_W  captured req_rd
wb_wen  out  1  1 for loads without error
wb_err  out  1  misaligned access

Behaviour:
- Reset: rst sampled low at posedge -> state IDLE; all outputs 0 except req_ready=1 after reset deasserts; internal regs cleared.
- FSM: IDLE -> REQ -> WAIT -> DONE -> IDLE.
- IDLE: req_ready=1. On req_valid, latch op/addr/wdata/rd.
  - If misaligned (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0), go to DONE with err=1, wen=0, data=0. No memory access.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1. Addr/wen/wdata/wmask are held stable until mem_req_ready=1, then go to WAIT.
- WAIT: wait for mem_resp_valid. On a load, latch the extended data. On a store, treat it as an ack. Go to DONE.
- DONE: wb_valid=1 with stable outputs until wb_ready=1, then go to IDLE. The next request is not accepted in that same cycle.
- mem_resp_valid outside WAIT is ignored. The memory never responds in the handshake cycle itself.
- Minimum latency, zero-wait memory: accept at cycle N, mem handshake at N+1, resp at N+2, wb_valid at N+3, ready again at N+4 if wb_ready=1 at N+3.
- Lane rules, with off=addr[2:0]:
  - wmask = ({1,3,15,255} for size) << off.
  - mem_req_wdata = req_wdata << (8*off).
  - Load: raw = mem_resp_rdata >> (8*off), truncated to the size, then sign-extended to XLEN, or zero-extended when op[2]=1. op[2] is ignored for D.
- Reset mid-operation: immediate return to IDLE. mem_req_valid and wb_valid drop in the same cycle. Any outstanding response is discarded: WAIT is gone, so it is ignored.
- Backpressure: an arbitrarily long mem_req_ready=0 or wb_ready=0 holds the state; no output changes.

Decomposition:
- Package ysyx_22050039_lsu_pkg:
  - state enum (IDLE/REQ/WAIT/DONE)
  - op field positions
  - size codes SZ_B/SZ_H/SZ_W/SZ_D
  - byte-mask constants
- Sub-module ysyx_22050039_lsu_align: purely combinational. Inputs: size, unsigned, off, wdata, rdata. Outputs: wmask, shifted wdata, extended load data, misaligned flag. The FSM and capture registers stay in the top.

Test Plan:
- Load LB: addr 0x80000003, rdata 0x11223344_55667788, signed -> wmask unused, mem_req_addr 0x80000000; wb_data 0x00000000_00000055 with wb_wen=1. Same with rdata byte3=0x85 -> 0xFFFFFFFF_FFFFFF85; LBU -> 0x85.
- Store SH: addr 0x80000006, wdata 0xABCD -> mem_req_wmask 0xC0, mem_req_wdata 0xABCD0000_00000000, wen=1; after ack, wb_valid=1, wb_wen=0.
- Misaligned LW at 0x80000002 -> no mem_req_valid ever; wb_valid next cycle with wb_err=1, wb_wen=0.
- Backpressure: hold mem_req_ready=0 5 cycles, then wb_ready=0 3 cycles -> outputs stable throughout, req_ready=0; single transaction completes.
- Back-to-back LD 0x80000008 then SD 0x80000010 with zero-wait memory -> second req_ready exactly 4 cycles after first accept; LD returns full 64-bit rdata.
- Reset asserted (rst=0) while in WAIT; late mem_resp_valid pulse arrives -> state IDLE, wb_valid stays 0, req_ready=1 after rst=1.
